// File: rtl/lsu_mem_if.sv
// Execute, data-memory and write-back handshake bundle for the LSU memory initiator.
// master = the LSU itself, slave = the execute stage / memory model / write-back side.
interface lsu_mem_if #(
    parameter int ADDR_W = 64
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_we;
    logic [2:0]        ex_size;
    logic [ADDR_W-1:0] ex_addr;
    logic [63:0]       ex_wdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [63:0]       mem_req_wdata;
    logic [7:0]        mem_req_wmask;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [63:0]       mem_resp_rdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [63:0]       wb_rdata;
    logic              wb_err;

    modport master (
        input  ex_valid, ex_we, ex_size, ex_addr, ex_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  wb_ready,
        output ex_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_resp_ready,
        output wb_valid, wb_rdata, wb_err
    );

    modport slave (
        output ex_valid, ex_we, ex_size, ex_addr, ex_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output wb_ready,
        input  ex_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_resp_ready,
        input  wb_valid, wb_rdata, wb_err
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: 8-byte-aligned masked memory requests, extended load results.
// Optional: define LSU_MISALIGN_CHK_EN to fault misaligned accesses instead of lane-truncating them.
module lsu_mem_master #(
    parameter int ADDR_W = 64
) (
    input logic       clk,
    input logic       rst_n,
    lsu_mem_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        size_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wmask_q;
    logic [63:0]       rdata_q;
    logic [7:0]        byte_en;
    logic              accept;
    logic              fault;

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  off,
                                                input logic [2:0]  size);
        logic [63:0] raw;
        raw = rdata >> {off, 3'b000};
        case (size[1:0])
            2'd0:    load_extend = size[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'd1:    load_extend = size[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_extend = size[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_extend = raw;
        endcase
    endfunction

    always_comb begin
        case (bus.ex_size[1:0])
            2'd0:    byte_en = 8'h01;
            2'd1:    byte_en = 8'h03;
            2'd2:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
    end

    assign accept = (state_q == IDLE) && bus.ex_valid;

`ifdef LSU_MISALIGN_CHK_EN
    logic err_q;
    // {byte_en[7], byte_en[3], byte_en[1]} is n-1, i.e. the offset bits that must be zero
    assign fault = |(bus.ex_addr[2:0] & {byte_en[7], byte_en[3], byte_en[1]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= fault;
        end else if (state_q == DONE && bus.wb_ready) begin
            err_q <= 1'b0;
        end
    end

    assign bus.wb_err = err_q;
`else
    assign fault      = 1'b0;
    assign bus.wb_err = 1'b0;
`endif

    always_comb begin
        state_d            = state_q;
        bus.ex_ready       = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b0;
        bus.wb_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ex_ready = 1'b1;
                if (bus.ex_valid) state_d = fault ? DONE : REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = RESP;
            end
            RESP: begin
                bus.mem_resp_ready = 1'b1;
                if (bus.mem_resp_valid) state_d = DONE;
            end
            DONE: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.ex_we;
                size_q  <= bus.ex_size;
                off_q   <= bus.ex_addr[2:0];
                addr_q  <= {bus.ex_addr[ADDR_W-1:3], 3'b000};
                // Bytes shifted past lane 7 are dropped: straddling accesses are never split
                wdata_q <= bus.ex_we ? (bus.ex_wdata << {bus.ex_addr[2:0], 3'b000}) : 64'd0;
                wmask_q <= bus.ex_we ? (byte_en << bus.ex_addr[2:0]) : 8'd0;
                rdata_q <= '0;
            end
            if (state_q == RESP && bus.mem_resp_valid) begin
                rdata_q <= we_q ? 64'd0 : load_extend(bus.mem_resp_rdata, off_q, size_q);
            end
        end
    end

    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;
    assign bus.wb_rdata      = rdata_q;
endmodule
